// File: rtl/dspl_fmt_bc.sv
// rtl/dspl_fmt_bc.sv - Bulls & Cows status to eight 6-bit display words formatter
module dspl_fmt_bc #(
  parameter int unsigned HALF_BLINK_COUNT   = 25000000,
  parameter int unsigned RESULT_HALF_BLINKS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  game_state,
  input  logic        player,
  input  logic [11:0] digs,
  input  logic [3:0]  dig_valid,
  input  logic [1:0]  cursor,
  input  logic        result_valid,
  input  logic [2:0]  bulls,
  input  logic [2:0]  cows,
  output logic [5:0]  d1,
  output logic [5:0]  d2,
  output logic [5:0]  d3,
  output logic [5:0]  d4,
  output logic [5:0]  d5,
  output logic [5:0]  d6,
  output logic [5:0]  d7,
  output logic [5:0]  d8,
  output logic        result_busy
);

  localparam logic [1:0] GS_SET   = 2'd0;
  localparam logic [1:0] GS_GUESS = 2'd1;
  localparam logic [1:0] GS_WIN   = 2'd2;

  localparam logic [3:0] G_Y     = 4'h4;
  localparam logic [3:0] G_S     = 4'h5;
  localparam logic [3:0] G_G     = 4'h6;
  localparam logic [3:0] G_T     = 4'h7;
  localparam logic [3:0] G_J     = 4'hB;
  localparam logic [3:0] G_V     = 4'hC;
  localparam logic [3:0] G_E     = 4'hE;
  localparam logic [3:0] G_PLACE = 4'hF;

  localparam logic [5:0] BLANK = 6'b0_1111_1;

  localparam logic [31:0] PRESC_LAST = 32'(HALF_BLINK_COUNT - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(RESULT_HALF_BLINKS);

  typedef enum logic {LIVE, RESULT} state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] presc;
  logic        blink_on;
  logic        tick;
  logic [7:0]  hold;
  logic [2:0]  bulls_q;
  logic [2:0]  cows_q;
  logic [2:0]  bulls_nx;
  logic [2:0]  cows_nx;
  logic [1:0]  cur_idx;
  logic [5:0]  page [8];

  function automatic logic [5:0] word(input logic en, input logic [3:0] glyph);
    return {en, glyph, 1'b1};
  endfunction

  function automatic logic [3:0] count_glyph(input logic [2:0] v);
    return (v <= 3'd4) ? {1'b0, v} : G_PLACE;
  endfunction

  assign tick    = (presc == PRESC_LAST);
  // cursor 0 addresses d4, which is digit index 3
  assign cur_idx = 2'd3 - cursor;

  // free-running blink timebase; never disturbed by result pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc    <= '0;
      blink_on <= 1'b1;
    end else if (tick) begin
      presc    <= '0;
      blink_on <= ~blink_on;
    end else begin
      presc <= presc + 32'd1;
    end
  end

  // next page owner: a new result wins over hold expiry
  always_comb begin
    state_nx = state;
    bulls_nx = bulls_q;
    cows_nx  = cows_q;
    if (result_valid) begin
      state_nx = RESULT;
      bulls_nx = bulls;
      cows_nx  = cows;
    end else if (state == RESULT && hold == HOLD_LAST) begin
      state_nx = LIVE;
    end
  end

  // page contents for the state about to be entered
  always_comb begin
    for (int i = 0; i < 8; i++) page[i] = BLANK;
    if (state_nx == RESULT) begin
      page[7] = word(1'b1, count_glyph(bulls_nx));
      page[6] = word(1'b1, G_T);
      page[4] = word(1'b1, count_glyph(cows_nx));
      page[3] = word(1'b1, G_V);
    end else begin
      case (game_state)
        GS_SET, GS_GUESS: begin
          page[7] = word(1'b1, G_J);
          page[6] = word(1'b1, player ? 4'd2 : 4'd1);
          page[4] = word(1'b1, (game_state == GS_GUESS) ? G_G : G_S);
          for (int k = 0; k < 4; k++) begin
            logic is_cur;
            logic show;
            is_cur  = (2'(k) == cur_idx);
            show    = dig_valid[k] && (is_cur || game_state == GS_GUESS);
            page[k] = word(is_cur ? blink_on : 1'b1,
                           show ? {1'b0, digs[k*3 +: 3]} : G_PLACE);
          end
        end
        GS_WIN: begin
          page[7] = word(blink_on, G_J);
          page[6] = word(blink_on, player ? 4'd2 : 4'd1);
          page[4] = word(blink_on, G_Y);
          page[3] = word(blink_on, G_E);
          page[2] = word(blink_on, G_S);
        end
        default: ;
      endcase
    end
  end

  // page FSM, result hold counter and registered display words
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= LIVE;
      hold        <= '0;
      bulls_q     <= '0;
      cows_q      <= '0;
      result_busy <= 1'b0;
      d1 <= BLANK;
      d2 <= BLANK;
      d3 <= BLANK;
      d4 <= BLANK;
      d5 <= BLANK;
      d6 <= BLANK;
      d7 <= BLANK;
      d8 <= BLANK;
    end else begin
      state   <= state_nx;
      bulls_q <= bulls_nx;
      cows_q  <= cows_nx;
      if (result_valid) begin
        hold <= '0;
      end else if (state == RESULT && tick) begin
        hold <= hold + 8'd1;
      end
      result_busy <= (state_nx == RESULT);
      d1 <= page[0];
      d2 <= page[1];
      d3 <= page[2];
      d4 <= page[3];
      d5 <= page[4];
      d6 <= page[5];
      d7 <= page[6];
      d8 <= page[7];
    end
  end

endmodule
